div_request_sequencer: RTL and testbench

//  Upstream issue stage for Div_mod_top_level.
//  - Accepts operand requests over a valid/ready handshake.
//  - Registers the operands and issues a one-cycle valid_input pulse to the divider.
//  - Waits for the divider's valid_output and returns the 17-bit result over a valid/ready response port.
//  - Short-circuits divide-by-zero, bounds the wait with a timeout and keeps saturating operation/error counters.

---
 rtl/div_request_sequencer.sv | 148 ++++++++++++++
 tb/tb_div_request_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_request_sequencer.sv
// Issue stage in front of the divider: one request in flight, divide-by-zero short-circuit,
// bounded wait for the result and saturating operation/error counters.
module div_request_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned STAT_W         = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [31:0]       req_dividend,
   input  logic [15:0]       req_divisor,
   input  logic              req_mode,
   output logic [31:0]       div_dividend,
   output logic [15:0]       div_divisor,
   output logic              div_mode,
   output logic              div_valid_input,
   input  logic              div_valid_output,
   input  logic [16:0]       div_result,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [16:0]       rsp_result,
   output logic              rsp_mode,
   output logic [1:0]        rsp_err,
   output logic [STAT_W-1:0] stat_ops,
   output logic [STAT_W-1:0] stat_errs
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_DIV0    = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       dividend_q, dividend_d;
   logic [15:0]       divisor_q, divisor_d;
   logic              mode_q, mode_d;
   logic [16:0]       result_q, result_d;
   logic              rsp_mode_q, rsp_mode_d;
   logic [1:0]        err_q, err_d;
   logic [STAT_W-1:0] ops_q, ops_d;
   logic [STAT_W-1:0] errs_q, errs_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      mode_d     = mode_q;
      result_d   = result_q;
      rsp_mode_d = rsp_mode_q;
      err_d      = err_q;
      ops_d      = ops_q;
      errs_d     = errs_q;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               dividend_d = req_dividend;
               divisor_d  = req_divisor;
               mode_d     = req_mode;
               rsp_mode_d = req_mode;
               if (req_divisor == 16'd0) begin
                  // Divider is never pulsed for a zero divisor.
                  result_d = '0;
                  err_d    = ERR_DIV0;
                  state_d  = RESP;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // A result arriving in the timeout cycle still wins.
            if (div_valid_output) begin
               result_d = div_result;
               err_d    = ERR_OK;
               state_d  = RESP;
            end else if (cnt_q == CNT_LAST) begin
               result_d = '0;
               err_d    = ERR_TIMEOUT;
               state_d  = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               if (ops_q != '1) ops_d = ops_q + 1'b1;
               if (err_q != ERR_OK && errs_q != '1) errs_d = errs_q + 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         dividend_q <= '0;
         divisor_q  <= '0;
         mode_q     <= 1'b0;
         result_q   <= '0;
         rsp_mode_q <= 1'b0;
         err_q      <= ERR_OK;
         ops_q      <= '0;
         errs_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         mode_q     <= mode_d;
         result_q   <= result_d;
         rsp_mode_q <= rsp_mode_d;
         err_q      <= err_d;
         ops_q      <= ops_d;
         errs_q     <= errs_d;
      end
   end

   assign req_ready       = (state_q == IDLE);
   assign div_valid_input = (state_q == ISSUE);
   assign rsp_valid       = (state_q == RESP);
   assign div_dividend    = dividend_q;
   assign div_divisor     = divisor_q;
   assign div_mode        = mode_q;
   assign rsp_result      = result_q;
   assign rsp_mode        = rsp_mode_q;
   assign rsp_err         = err_q;
   assign stat_ops        = ops_q;
   assign stat_errs       = errs_q;

endmodule

// File: tb/tb_div_request_sequencer.sv
// Directed bench for div_request_sequencer: vector table plus reset, timeout and saturation
// sequences; a second instance with 2-bit counters shares the stimulus.
module tb_div_request_sequencer;

   typedef struct {
      logic [31:0] dividend;
      logic [15:0] divisor;
      logic        mode;
      int          lat;        // WAIT cycles before the divider answers, -1 = never
      logic [16:0] result;
      int          hold;       // cycles rsp_ready stays low
      logic [16:0] exp_result;
      logic [1:0]  exp_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_mode, div_valid_output, rsp_ready;
   logic [31:0] req_dividend;
   logic [15:0] req_divisor;
   logic [16:0] div_result;

   logic        req_ready, div_mode, div_valid_input, rsp_valid, rsp_mode;
   logic [31:0] div_dividend;
   logic [15:0] div_divisor;
   logic [16:0] rsp_result;
   logic [1:0]  rsp_err;
   logic [15:0] stat_ops, stat_errs;

   logic        s_req_ready, s_div_mode, s_div_valid_input, s_rsp_valid, s_rsp_mode;
   logic [31:0] s_div_dividend;
   logic [15:0] s_div_divisor;
   logic [16:0] s_rsp_result;
   logic [1:0]  s_rsp_err;
   logic [1:0]  s_stat_ops, s_stat_errs;

   int checks = 0;
   int errors = 0;
   int pulses = 0;
   int cur = -1;
   int exp_ops = 0;
   int exp_errs = 0;
   vec_t vecs[8];

   always #5 clk = ~clk;

   always @(posedge clk) if (div_valid_input) pulses++;

   div_request_sequencer dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_dividend(req_dividend),
      .req_divisor(req_divisor), .req_mode(req_mode),
      .div_dividend(div_dividend), .div_divisor(div_divisor), .div_mode(div_mode),
      .div_valid_input(div_valid_input), .div_valid_output(div_valid_output),
      .div_result(div_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_mode(rsp_mode), .rsp_err(rsp_err), .stat_ops(stat_ops), .stat_errs(stat_errs)
   );

   div_request_sequencer #(.STAT_W(2)) dut_sat (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(s_req_ready), .req_dividend(req_dividend),
      .req_divisor(req_divisor), .req_mode(req_mode),
      .div_dividend(s_div_dividend), .div_divisor(s_div_divisor), .div_mode(s_div_mode),
      .div_valid_input(s_div_valid_input), .div_valid_output(div_valid_output),
      .div_result(div_result),
      .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(s_rsp_result),
      .rsp_mode(s_rsp_mode), .rsp_err(s_rsp_err), .stat_ops(s_stat_ops),
      .stat_errs(s_stat_errs)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (vector %0d): got %0h, expected %0h", name, cur, act, exp);
      end
   endtask

   task automatic chk_stats();
      chk("stat_ops", stat_ops, 64'(exp_ops));
      chk("stat_errs", stat_errs, 64'(exp_errs));
      chk("sat_stat_ops", s_stat_ops, 64'((exp_ops > 3) ? 3 : exp_ops));
      chk("sat_stat_errs", s_stat_errs, 64'((exp_errs > 3) ? 3 : exp_errs));
   endtask

   task automatic run_vec(input vec_t v);
      int p0;
      int n;
      p0 = pulses;
      @(negedge clk);
      chk("req_ready_idle", req_ready, 1);
      req_valid    = 1'b1;
      req_dividend = v.dividend;
      req_divisor  = v.divisor;
      req_mode     = v.mode;
      @(negedge clk);
      req_valid    = 1'b0;
      req_dividend = ~v.dividend;
      req_divisor  = ~v.divisor;
      req_mode     = ~v.mode;
      chk("div_dividend", div_dividend, 64'(v.dividend));
      chk("div_divisor", div_divisor, 64'(v.divisor));
      chk("div_mode", div_mode, 64'(v.mode));
      if (v.divisor == 16'd0) begin
         chk("div0_rsp_next_cycle", rsp_valid, 1);
         chk("div0_no_issue", div_valid_input, 0);
      end else begin
         chk("issue_pulse", div_valid_input, 1);
         chk("issue_req_ready", req_ready, 0);
         @(negedge clk);
         chk("issue_single_cycle", div_valid_input, 0);
         if (v.lat >= 0) begin
            repeat (v.lat) @(negedge clk);
            chk("no_early_rsp", rsp_valid, 0);
            div_valid_output = 1'b1;
            div_result       = v.result;
            @(negedge clk);
            div_valid_output = 1'b0;
            div_result       = 17'h0BEEF;
            chk("rsp_after_result", rsp_valid, 1);
         end else begin
            n = 0;
            while (!rsp_valid && n < 200) begin
               @(negedge clk);
               n++;
            end
            chk("timeout_wait_cycles", 64'(n), 64);
         end
      end
      chk("rsp_result", rsp_result, 64'(v.exp_result));
      chk("rsp_err", rsp_err, 64'(v.exp_err));
      chk("rsp_mode", rsp_mode, 64'(v.mode));
      for (int i = 0; i < v.hold; i++) begin
         req_valid        = 1'b1;
         req_dividend     = 32'h1234;
         req_divisor      = 16'd9;
         div_valid_output = 1'b1;
         div_result       = 17'h1FFFF;
         @(negedge clk);
         chk("hold_rsp_valid", rsp_valid, 1);
         chk("hold_rsp_result", rsp_result, 64'(v.exp_result));
         chk("hold_req_ready", req_ready, 0);
         chk("hold_div_dividend", div_dividend, 64'(v.dividend));
      end
      req_valid        = 1'b0;
      div_valid_output = 1'b0;
      rsp_ready        = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      exp_ops++;
      if (v.exp_err != 2'b00) exp_errs++;
      chk("rsp_done", rsp_valid, 0);
      chk("req_ready_after_rsp", req_ready, 1);
      chk("issue_pulse_count", 64'(pulses - p0), (v.divisor != 16'd0) ? 64'd1 : 64'd0);
      chk_stats();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{-32'sd80, 16'sd3, 1'b1, 10, -17'sd26, 0, -17'sd26, 2'b00};
      vecs[1] = '{32'sd100, 16'sd0, 1'b0, 0, 17'sd0, 0, 17'sd0, 2'b01};
      vecs[2] = '{32'sd1000, 16'sd7, 1'b0, -1, 17'sd0, 3, 17'sd0, 2'b10};
      vecs[3] = '{32'sd49, 16'sd7, 1'b0, 3, 17'sd7, 20, 17'sd7, 2'b00};
      vecs[4] = '{32'sd12345, -16'sd5, 1'b1, 1, -17'sd2469, 2, -17'sd2469, 2'b00};
      vecs[5] = '{-32'sd7, 16'sd2, 1'b0, 0, -17'sd3, 0, -17'sd3, 2'b00};
      vecs[6] = '{32'sd640, 16'sd10, 1'b1, 63, 17'sd64, 1, 17'sd64, 2'b00};
      vecs[7] = '{32'sd640, 16'sd10, 1'b1, 62, 17'sd64, 0, 17'sd64, 2'b00};

      reset            = 1'b0;
      req_valid        = 1'b0;
      req_dividend     = '0;
      req_divisor      = '0;
      req_mode         = 1'b0;
      div_valid_output = 1'b0;
      div_result       = '0;
      rsp_ready        = 1'b0;
      #3;
      chk("reset_req_ready", req_ready, 1);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_div_valid_input", div_valid_input, 0);
      chk("reset_div_dividend", div_dividend, 0);
      chk("reset_rsp_err", rsp_err, 0);
      chk_stats();
      @(negedge clk);
      reset = 1'b1;

      for (int k = 0; k < 8; k++) begin
         cur = k;
         run_vec(vecs[k]);
         if (vecs[k].lat < 0) begin
            // Late answer after a timeout must not create a response.
            div_valid_output = 1'b1;
            div_result       = 17'd5;
            @(negedge clk);
            div_valid_output = 1'b0;
            chk("late_result_ignored", rsp_valid, 0);
            chk("late_result_req_ready", req_ready, 1);
         end
      end

      // Reset while waiting for the divider.
      cur = 100;
      @(negedge clk);
      req_valid    = 1'b1;
      req_dividend = 32'd500;
      req_divisor  = 16'd5;
      req_mode     = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("pre_reset_in_wait", req_ready, 0);
      #2 reset = 1'b0;
      #1;
      chk("midreset_req_ready", req_ready, 1);
      chk("midreset_rsp_valid", rsp_valid, 0);
      chk("midreset_div_valid_input", div_valid_input, 0);
      chk("midreset_div_dividend", div_dividend, 0);
      chk("midreset_div_mode", div_mode, 0);
      exp_ops  = 0;
      exp_errs = 0;
      chk_stats();
      @(negedge clk);
      reset = 1'b1;
      div_valid_output = 1'b1;
      div_result       = 17'd100;
      @(negedge clk);
      div_valid_output = 1'b0;
      repeat (3) @(negedge clk);
      chk("no_rsp_after_reset", rsp_valid, 0);
      cur = 101;
      run_vec(vecs[0]);

      // Five divide-by-zero requests saturate the 2-bit counters.
      for (int k = 0; k < 5; k++) begin
         cur = 200 + k;
         run_vec(vecs[1]);
      end
      chk("sat_ops_final", s_stat_ops, 3);
      chk("sat_errs_final", s_stat_errs, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
